mixpix_readout_buf: RTL and testbench

// - Downstream stage of the MixPix pixel FSM.
// - Captures the 16-bit pixel result each time the pixel FSM signals kernel completion.
// - Tags each result with a rolling kernel index and queues it in a small first-word-fall-through FIFO.
// - Lets the Wishbone register file drain results at its own pace, with fill-level, overflow and IRQ status.

---
 rtl/mixpix_pkg.sv | 33 +++
 rtl/mixpix_readout_buf_if.sv | 27 ++
 rtl/mixpix_sync_fifo.sv | 71 +++++++
 rtl/mixpix_readout_buf.sv | 75 +++++++
 tb/tb_mixpix_readout_buf.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mixpix_pkg.sv
// Shared constants and types for the MixPix readout path: default geometry,
// Wishbone register map of the readout block and the packed status word.
package mixpix_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_TAG_W  = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_THRESH = 4;
    localparam int DEF_CNT_W  = $clog2(DEF_DEPTH) + 1;

    localparam logic [7:0] WB_ADDR_READOUT = 8'h10;
    localparam logic [7:0] WB_ADDR_STATUS  = 8'h14;
    localparam logic [7:0] WB_ADDR_CLEAR   = 8'h18;

    typedef struct packed {
        logic                 ovf;
        logic                 irq;
        logic                 valid;
        logic [DEF_CNT_W-1:0] count;
    } status_t;

    function automatic status_t pack_status(input logic ovf, input logic irq,
                                            input logic valid,
                                            input logic [DEF_CNT_W-1:0] count);
        status_t st;
        st.ovf   = ovf;
        st.irq   = irq;
        st.valid = valid;
        st.count = count;
        return st;
    endfunction

endpackage

// File: rtl/mixpix_readout_buf_if.sv
// Bundle between the pixel FSM / Wishbone register file (master) and the
// readout buffer (slave).
interface mixpix_readout_buf_if #(
    parameter int DATA_W = mixpix_pkg::DEF_DATA_W,
    parameter int TAG_W  = mixpix_pkg::DEF_TAG_W,
    parameter int DEPTH  = mixpix_pkg::DEF_DEPTH
) ();
    logic                       kernel_done_i;
    logic [DATA_W-1:0]          data_i;
    logic                       clear_i;
    logic                       rd_en_i;
    logic [TAG_W+DATA_W-1:0]    rd_data_o;
    logic                       rd_valid_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       ovf_o;
    logic                       irq_o;

    modport master (
        output kernel_done_i, data_i, clear_i, rd_en_i,
        input  rd_data_o, rd_valid_o, count_o, ovf_o, irq_o
    );

    modport slave (
        input  kernel_done_i, data_i, clear_i, rd_en_i,
        output rd_data_o, rd_valid_o, count_o, ovf_o, irq_o
    );
endinterface

// File: rtl/mixpix_sync_fifo.sv
// Generic first-word-fall-through FIFO with separate fill counter; a write
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module mixpix_sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          rd_ok_s;
    logic          wr_ok_s;

    assign empty   = (count_r == CW'(0));
    assign full    = (count_r == CW'(DEPTH));
    assign count   = count_r;
    assign rd_ok_s = rd_en & ~empty;
    assign wr_ok_s = wr_en & (~full | rd_ok_s);

    // Head word; forced to zero when empty so stale storage never leaks out.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    // Pointer and fill-level bookkeeping; clear wins over any push/pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until referenced by a valid pointer.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !clr && !rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/mixpix_readout_buf.sv
// Readout buffer behind the MixPix pixel FSM: captures each finished kernel
// result with a rolling tag and queues it for the Wishbone register file.
module mixpix_readout_buf
    import mixpix_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int THRESH = DEF_THRESH
) (
    input  logic clk,
    input  logic rst,
    mixpix_readout_buf_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              kd_r;
    logic [TAG_W-1:0]  tag_r;
    logic              ovf_r;
    logic              capture_s;
    logic              pop_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;

    // kd_r resets high so a level already asserted at reset release is ignored.
    assign capture_s = bus.kernel_done_i & ~kd_r;
    assign pop_s     = bus.rd_en_i & ~empty_s;
    assign drop_s    = capture_s & full_s & ~pop_s;

    mixpix_sync_fifo #(
        .W     (TAG_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clear_i),
        .wr_en (capture_s & ~bus.clear_i),
        .rd_en (bus.rd_en_i & ~bus.clear_i),
        .din   ({tag_r, bus.data_i}),
        .dout  (bus.rd_data_o),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Edge detector, rolling tag (counts dropped captures too) and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            kd_r  <= 1'b1;
            tag_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            kd_r <= bus.kernel_done_i;
            if (bus.clear_i) begin
                tag_r <= '0;
                ovf_r <= 1'b0;
            end else begin
                if (capture_s) begin
                    tag_r <= tag_r + TAG_W'(1);
                end
                if (drop_s) begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

    assign bus.count_o    = count_s;
    assign bus.rd_valid_o = ~empty_s;
    assign bus.irq_o      = (count_s >= CW'(THRESH));
    assign bus.ovf_o      = ovf_r;

endmodule

// File: tb/tb_mixpix_readout_buf.sv
// Directed scoreboard bench for mixpix_readout_buf: stimulus pushes expected
// {tag, data} words, a negedge monitor compares every popped head word.
module tb_mixpix_readout_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_w;

    mixpix_readout_buf_if bus_if ();

    mixpix_readout_buf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Monitor: every accepted pop must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus_if.rd_en_i && !bus_if.clear_i && bus_if.rd_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, scoreboard empty", bus_if.rd_data_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus_if.rd_data_o !== exp_w) begin
                    errors++;
                    $display("FAIL pop_data: got %h, expected %h", bus_if.rd_data_o, exp_w);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic kd, input logic [15:0] d, input logic clr, input logic rd);
        bus_if.kernel_done_i = kd;
        bus_if.data_i        = d;
        bus_if.clear_i       = clr;
        bus_if.rd_en_i       = rd;
        @(posedge clk);
        #2;
    endtask

    task automatic cap(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        bus_if.kernel_done_i = 1'b0;
        bus_if.data_i        = 16'h0000;
        bus_if.clear_i       = 1'b0;
        bus_if.rd_en_i       = 1'b0;
        @(posedge clk);
        #2;
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        chk("reset_count", 32'(bus_if.count_o), 32'd0);
        chk("reset_valid", 32'(bus_if.rd_valid_o), 32'd0);
        chk("reset_irq", 32'(bus_if.irq_o), 32'd0);
        chk("reset_ovf", 32'(bus_if.ovf_o), 32'd0);
        chk("reset_data", 32'(bus_if.rd_data_o), 32'd0);

        // Single kernel result
        exp_q.push_back(24'h00A5A5);
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        chk("single_valid", 32'(bus_if.rd_valid_o), 32'd1);
        chk("single_count", 32'(bus_if.count_o), 32'd1);
        chk("single_data", 32'(bus_if.rd_data_o), 32'h00A5A5);
        step(1'b0, 16'hA5A5, 1'b0, 1'b0);
        pop_n(1);
        chk("single_drained", 32'(bus_if.count_o), 32'd0);

        // Fill and overflow: tag 8 (data 9) is dropped
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back({8'(i - 1), 16'(i)});
            cap(16'(i));
        end
        chk("fill_count", 32'(bus_if.count_o), 32'd8);
        chk("fill_ovf", 32'(bus_if.ovf_o), 32'd1);
        chk("fill_irq", 32'(bus_if.irq_o), 32'd1);
        pop_n(8);
        chk("fill_drained", 32'(bus_if.count_o), 32'd0);
        chk("fill_ovf_sticky", 32'(bus_if.ovf_o), 32'd1);

        // Full with simultaneous capture and pop
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("clear_ovf", 32'(bus_if.ovf_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({8'(i), 16'h0100 + 16'(i)});
            cap(16'h0100 + 16'(i));
        end
        exp_q.push_back(24'h080BEE);
        step(1'b1, 16'h0BEE, 1'b0, 1'b1);
        chk("fullrw_count", 32'(bus_if.count_o), 32'd8);
        chk("fullrw_ovf", 32'(bus_if.ovf_o), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        pop_n(8);
        chk("fullrw_drained", 32'(bus_if.count_o), 32'd0);

        // IRQ threshold
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'(i), 16'h0010 + 16'(i)});
            cap(16'h0010 + 16'(i));
        end
        chk("irq_at3", 32'(bus_if.irq_o), 32'd0);
        exp_q.push_back(24'h030013);
        cap(16'h0013);
        chk("irq_at4", 32'(bus_if.irq_o), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("irq_after_pop", 32'(bus_if.irq_o), 32'd0);
        chk("irq_count3", 32'(bus_if.count_o), 32'd3);
        pop_n(3);

        // Clear with coincident capture
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        exp_q.push_back(24'h005555);
        cap(16'h5555);
        exp_q.delete();
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        chk("clrcap_count", 32'(bus_if.count_o), 32'd0);
        chk("clrcap_ovf", 32'(bus_if.ovf_o), 32'd0);
        chk("clrcap_valid", 32'(bus_if.rd_valid_o), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        exp_q.push_back(24'h001234);
        cap(16'h1234);
        chk("clrcap_tag0", 32'(bus_if.rd_data_o), 32'h001234);
        pop_n(1);

        // Reset mid-operation with kernel_done held high
        cap(16'h0AAA);
        cap(16'h0BBB);
        rst = 1'b1;
        step(1'b1, 16'h0CCC, 1'b0, 1'b0);
        step(1'b1, 16'h0CCC, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 16'h0CCC, 1'b0, 1'b0);
        step(1'b1, 16'h0CCC, 1'b0, 1'b0);
        chk("rsthold_count", 32'(bus_if.count_o), 32'd0);
        chk("rsthold_valid", 32'(bus_if.rd_valid_o), 32'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        exp_q.push_back(24'h000C0C);
        step(1'b1, 16'h0C0C, 1'b0, 1'b0);
        chk("rsthold_count1", 32'(bus_if.count_o), 32'd1);
        chk("rsthold_data", 32'(bus_if.rd_data_o), 32'h000C0C);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("rsthold_drained", 32'(bus_if.count_o), 32'd0);

        // Empty pop, then capture with pop on an empty FIFO
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("emptypop_count", 32'(bus_if.count_o), 32'd0);
        chk("emptypop_data", 32'(bus_if.rd_data_o), 32'd0);
        exp_q.push_back(24'h017777);
        step(1'b1, 16'h7777, 1'b0, 1'b1);
        chk("emptycap_count", 32'(bus_if.count_o), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("emptycap_drained", 32'(bus_if.count_o), 32'd0);

        // Tag wrap: 258 captures, each popped right after
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 258; i++) begin
            exp_q.push_back({8'(i), 16'(i)});
            step(1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 255) chk("wrap_tagff", 32'(bus_if.rd_data_o), 32'hFF00FF);
            if (i == 256) chk("wrap_tag00", 32'(bus_if.rd_data_o), 32'h000100);
            step(1'b0, 16'(i), 1'b0, 1'b1);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("wrap_drained", 32'(bus_if.count_o), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
